lohi_unit: RTL and testbench

- Parametrised iterative multiply/divide unit owning the LO/HI register pair; successor to the current multiply-only LO/HI wrapper.
- Adds signed/unsigned divide, configurable operand width, cancel on pipeline clear, and a start/ready handshake.
- Driven by the EX stage (start, operands); the MEM stage reads LO/HI and issues LO/HI writes.
- One radix-2 iteration per clock; no multiplier primitives inferred.

---
 rtl/lohi_unit.sv | 191 +++++++++++++++++++
 tb/tb_lohi_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lohi_unit.sv
`default_nettype none
// ============================================================================
// Module   : lohi_unit
// Brief    : Iterative radix-2 multiply/divide unit owning the LO/HI pair.
// Revision : 1.0
// ============================================================================
module lohi_unit #(
    parameter int WIDTH    = 32,
    parameter int OP_WIDTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [OP_WIDTH-1:0] op,
    input  logic [WIDTH-1:0]    opr1,
    input  logic [WIDTH-1:0]    opr2,
    input  logic                cancel,
    input  logic [1:0]          write_opt,
    input  logic [WIDTH-1:0]    write_data,
    output logic                ready,
    output logic                done,
    output logic [WIDTH-1:0]    lo,
    output logic [WIDTH-1:0]    hi
);

    localparam int               CNT_W      = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [WIDTH-1:0] c_one      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] c_one2   = {{(2*WIDTH-1){1'b0}}, 1'b1};

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_load = 2'd1;
    localparam logic [1:0] c_st_iter = 2'd2;
    localparam logic [1:0] c_st_fix  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic             r_is_div;
    logic             r_is_unsigned;
    logic [WIDTH-1:0] r_opr1;
    logic [WIDTH-1:0] r_opr2;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic             r_neg_res;
    logic             r_neg_rem;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic             r_done;

    logic             w_abort;
    logic             w_accept;
    logic             w_neg1;
    logic             w_neg2;
    logic [WIDTH-1:0] w_mag1;
    logic [WIDTH-1:0] w_mag2;

    // Any register write or pipeline clear kills an in-flight operation.
    assign w_abort  = (write_opt != 2'b00) || cancel;
    assign w_accept = start && (write_opt == 2'b00);

    assign w_neg1 = !r_is_unsigned && r_opr1[WIDTH-1];
    assign w_neg2 = !r_is_unsigned && r_opr2[WIDTH-1];
    assign w_mag1 = w_neg1 ? (~r_opr1 + c_one) : r_opr1;
    assign w_mag2 = w_neg2 ? (~r_opr2 + c_one) : r_opr2;

    // Shift-add step: {A,Q} shifts right with the carry of A + M.
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_mul_a;
    logic [WIDTH-1:0] w_mul_q;
    assign w_sum   = {1'b0, r_a} + (r_q[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});
    assign w_mul_a = w_sum[WIDTH:1];
    assign w_mul_q = {w_sum[0], r_q[WIDTH-1:1]};

    // Restoring step: the remainder stays below M, so bit WIDTH of the
    // difference is a pure borrow flag.
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_div_a;
    logic [WIDTH-1:0] w_div_q;
    assign w_shift = {r_a, r_q[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_m};
    assign w_ge    = !w_diff[WIDTH];
    assign w_div_a = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_div_q = {r_q[WIDTH-2:0], w_ge};

    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_neg;
    logic [WIDTH-1:0]   w_res_lo;
    logic [WIDTH-1:0]   w_res_hi;
    assign w_prod     = {r_a, r_q};
    assign w_prod_neg = ~w_prod + c_one2;

    always_comb begin
        w_res_lo = r_q;
        w_res_hi = r_a;
        if (!r_is_div) begin
            {w_res_hi, w_res_lo} = r_neg_res ? w_prod_neg : w_prod;
        end else if (r_m == {WIDTH{1'b0}}) begin
            w_res_lo = {WIDTH{1'b1}};
            w_res_hi = r_opr1;
        end else begin
            w_res_lo = r_neg_res ? (~r_q + c_one) : r_q;
            w_res_hi = r_neg_rem ? (~r_a + c_one) : r_a;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ready       = 1'b0;
        case (r_state)
            c_st_idle: begin
                ready = 1'b1;
                if (w_accept) w_state_nxt = c_st_load;
            end
            c_st_load: w_state_nxt = w_abort ? c_st_idle : c_st_iter;
            c_st_iter: begin
                if (w_abort)                     w_state_nxt = c_st_idle;
                else if (r_count == c_cnt_last)  w_state_nxt = c_st_fix;
            end
            c_st_fix:  w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= c_st_idle;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count       <= '0;
            r_is_div      <= 1'b0;
            r_is_unsigned <= 1'b0;
            r_opr1        <= '0;
            r_opr2        <= '0;
            r_a           <= '0;
            r_q           <= '0;
            r_m           <= '0;
            r_neg_res     <= 1'b0;
            r_neg_rem     <= 1'b0;
            r_lo          <= '0;
            r_hi          <= '0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_is_div      <= op[1];
                        r_is_unsigned <= op[0];
                        r_opr1        <= opr1;
                        r_opr2        <= opr2;
                    end
                end
                c_st_load: begin
                    r_a       <= '0;
                    r_q       <= w_mag1;
                    r_m       <= w_mag2;
                    r_neg_res <= w_neg1 ^ w_neg2;
                    r_neg_rem <= w_neg1;
                    r_count   <= '0;
                end
                c_st_iter: begin
                    r_a     <= r_is_div ? w_div_a : w_mul_a;
                    r_q     <= r_is_div ? w_div_q : w_mul_q;
                    r_count <= r_count + c_cnt_one;
                end
                default: begin
                    if (!w_abort) begin
                        r_lo   <= w_res_lo;
                        r_hi   <= w_res_hi;
                        r_done <= 1'b1;
                    end
                end
            endcase
            if (write_opt[0]) r_lo <= write_data;
            if (write_opt[1]) r_hi <= write_data;
        end
    end

    assign lo   = r_lo;
    assign hi   = r_hi;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_lohi_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_lohi_unit
// Brief    : Self-checking bench for lohi_unit with a cycle-level reference.
// Revision : 1.0
// ============================================================================
module tb_lohi_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] opr1;
    logic [W-1:0] opr2;
    logic         cancel;
    logic [1:0]   write_opt;
    logic [W-1:0] write_data;
    logic         ready;
    logic         done;
    logic [W-1:0] lo;
    logic [W-1:0] hi;

    always #5 clk = ~clk;

    lohi_unit #(.WIDTH(W), .OP_WIDTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .opr1       (opr1),
        .opr2       (opr2),
        .cancel     (cancel),
        .write_opt  (write_opt),
        .write_data (write_data),
        .ready      (ready),
        .done       (done),
        .lo         (lo),
        .hi         (hi)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: remaining busy cycles plus the result the operation will commit.
    int           m_busy   = 0;
    logic [W-1:0] m_lo     = '0;
    logic [W-1:0] m_hi     = '0;
    logic [W-1:0] m_res_lo = '0;
    logic [W-1:0] m_res_hi = '0;
    logic         m_done   = 1'b0;
    bit           m_valid  = 1'b0;

    function automatic logic [2*W-1:0] ref_result(input logic [1:0] o,
                                                  input logic [W-1:0] a,
                                                  input logic [W-1:0] b);
        longint sa, sb, q, r;
        logic [2*W-1:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {{W{1'b0}}, a};
        ub = {{W{1'b0}}, b};
        case (o)
            2'b00: return 64'(sa * sb);
            2'b01: return ua * ub;
            2'b10: begin
                if (b == '0) return {a, {W{1'b1}}};
                q = sa / sb;
                r = sa % sb;
                return {r[W-1:0], q[W-1:0]};
            end
            default: begin
                if (b == '0) return {a, {W{1'b1}}};
                return {W'(ua % ub), W'(ua / ub)};
            end
        endcase
    endfunction

    always @(posedge clk) begin
        m_valid <= 1'b1;
        if (!rst) begin
            m_busy <= 0;
            m_lo   <= '0;
            m_hi   <= '0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (write_opt != 2'b00) begin
                m_busy <= 0;
                if (write_opt[0]) m_lo <= write_data;
                if (write_opt[1]) m_hi <= write_data;
            end else if (m_busy > 0 && cancel) begin
                m_busy <= 0;
            end else if (m_busy > 0) begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) begin
                    m_lo   <= m_res_lo;
                    m_hi   <= m_res_hi;
                    m_done <= 1'b1;
                end
            end else if (start) begin
                {m_res_hi, m_res_lo} <= ref_result(op, opr1, opr2);
                m_busy <= W + 2;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            n_checks++;
            if (ready === (m_busy == 0) && done === m_done && lo === m_lo && hi === m_hi)
                n_pass++;
            else
                $display("FAIL cycle_cmp t=%0t: ready/done/lo/hi got %b/%b/%h/%h expected %b/%b/%h/%h",
                         $time, ready, done, lo, hi, (m_busy == 0), m_done, m_lo, m_hi);
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Entered on a negedge with the unit idle; leaves one cycle after completion.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] elo, input logic [W-1:0] ehi, input string name);
        int cyc;
        op = o; opr1 = a; opr2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (ready !== 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        check({name, "_latency"}, 64'(cyc), 64'(W + 2));
        check({name, "_done"}, 64'(done), 64'd1);
        check({name, "_lo"}, 64'(lo), 64'(elo));
        check({name, "_hi"}, 64'(hi), 64'(ehi));
        @(negedge clk);
        check({name, "_done_drop"}, 64'(done), 64'd0);
    endtask

    function automatic logic [W-1:0] rand_opnd();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1'b0; start = 1'b0; cancel = 1'b0; op = 2'b00;
        opr1 = '0; opr2 = '0; write_opt = 2'b00; write_data = '0;
        repeat (3) @(negedge clk);
        check("reset_ready", 64'(ready), 64'd1);
        check("reset_done", 64'(done), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        run_op(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 32'hFFFF_FFFF, "mult_neg");
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, "multu_max");
        run_op(2'b11, 32'd100, 32'd7, 32'd14, 32'd2, "divu");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "div_neg");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, "div_ovf");
        run_op(2'b11, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678, "divu_zero");
        run_op(2'b10, 32'h8000_0005, 32'h0, 32'hFFFF_FFFF, 32'h8000_0005, "div_zero_neg");

        // Cancel during ITER with an ignored start while busy.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        op = 2'b00; opr1 = 32'd5; opr2 = 32'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        op = 2'b01; opr1 = 32'd7; opr2 = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_ready", 64'(ready), 64'd1);
        check("cancel_done", 64'(done), 64'd0);
        check("cancel_lo", 64'(lo), 64'd0);
        check("cancel_hi", 64'(hi), 64'd0);
        repeat (40) @(negedge clk);
        check("cancel_noqueue_lo", 64'(lo), 64'd0);

        // Register write aborts an operation in ITER.
        run_op(2'b11, 32'd100, 32'd7, 32'd14, 32'd2, "divu_pre");
        op = 2'b01; opr1 = 32'd9; opr2 = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        write_opt = 2'b01; write_data = 32'hDEAD_BEEF;
        @(negedge clk);
        write_opt = 2'b00;
        check("wr_abort_ready", 64'(ready), 64'd1);
        check("wr_abort_lo", 64'(lo), 64'hDEAD_BEEF);
        check("wr_abort_hi", 64'(hi), 64'd2);
        repeat (40) @(negedge clk);
        check("wr_abort_lo_hold", 64'(lo), 64'hDEAD_BEEF);

        // Write in IDLE beats a simultaneous start.
        write_opt = 2'b10; write_data = 32'hCAFE_F00D; start = 1'b1;
        @(negedge clk);
        write_opt = 2'b00; start = 1'b0;
        check("idle_wr_ready", 64'(ready), 64'd1);
        check("idle_wr_hi", 64'(hi), 64'hCAFE_F00D);

        // Reset during ITER.
        op = 2'b00; opr1 = 32'd3; opr2 = 32'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("rst_mid_ready", 64'(ready), 64'd1);
        check("rst_mid_lo", 64'(lo), 64'd0);
        check("rst_mid_hi", 64'(hi), 64'd0);

        for (int i = 0; i < 6000; i++) begin
            start = 1'b0; cancel = 1'b0; write_opt = 2'b00; rst = 1'b1;
            if ($urandom_range(0, 499) == 0) rst = 1'b0;
            if (m_busy == 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    start = 1'b1;
                    op    = 2'($urandom);
                    opr1  = rand_opnd();
                    opr2  = rand_opnd();
                end
                if ($urandom_range(0, 15) == 0) begin
                    write_opt  = 2'($urandom);
                    write_data = W'($urandom);
                end
            end else begin
                start = ($urandom_range(0, 7) == 0);
                opr1  = W'($urandom);
                opr2  = W'($urandom);
                if ($urandom_range(0, 63) == 0) cancel = 1'b1;
                if ($urandom_range(0, 63) == 0) begin
                    write_opt  = 2'($urandom_range(1, 3));
                    write_data = W'($urandom);
                end
            end
            @(negedge clk);
        end
        start = 1'b0; cancel = 1'b0; write_opt = 2'b00; rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
